usb_cmd_reader: RTL



---
 rtl/usb_cmd_reader_pkg.sv | 21 ++
 rtl/usb_fifo_byte_reader.sv | 56 +++++
 rtl/usb_cmd_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/usb_cmd_reader_pkg.sv
// Shared constants and FSM encoding for the FX2 EP2 command reader.
// Packet format: 0xAA + 16-bit data, or 0b0 + 23-bit address (3 bytes each).
package usb_cmd_reader_pkg;

    localparam int          ADDR_W     = 23;
    localparam int          DATA_W     = 16;
    localparam logic [7:0]  PKT_MARKER = 8'hAA;
    localparam logic [1:0]  FIFO_ADDR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } fetch_state_t;

    // Address packets are flagged by a clear MSB in the first byte.
    function automatic logic is_addr_hdr(input logic [7:0] b);
        return ~b[7];
    endfunction

endpackage

// File: rtl/usb_fifo_byte_reader.sv
// Pops single bytes from the FX2 slave FIFO: IDLE -> STROBE (SLRD low) -> WAIT.
// byte_valid_o marks the strobe cycle; the consumer samples byte_o on the edge that ends it.
module usb_fifo_byte_reader
    import usb_cmd_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] usb_d_i,
    input  logic       usb_flaga_i,
    input  logic       hold_i,
    output logic       usb_slrd_o,
    output logic       usb_sloe_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    fetch_state_t state_q;
    logic         slrd_q;
    logic         sloe_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            slrd_q  <= 1'b1;
            sloe_q  <= 1'b1;
        end else begin
            sloe_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (usb_flaga_i && !hold_i) begin
                        state_q <= ST_STROBE;
                        slrd_q  <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    state_q <= ST_WAIT;
                    slrd_q  <= 1'b1;
                end
                // One idle-high cycle so FLAGA reflects the pop before the next decision.
                ST_WAIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    slrd_q  <= 1'b1;
                end
            endcase
        end
    end

    assign usb_slrd_o   = slrd_q;
    assign usb_sloe_o   = sloe_q;
    assign byte_o       = usb_d_i;
    assign byte_valid_o = (state_q == ST_STROBE);

endmodule

// File: rtl/usb_cmd_reader.sv
// Reassembles 3-byte address/data packets from FX2 EP2 and presents them on valid/ready.
// Optional: USB_CMD_ADDR_AUTOINC_EN makes accepted data packets advance an internal address.
module usb_cmd_reader
    import usb_cmd_reader_pkg::*;
(
    input  logic              mclk,
    input  logic              reset,
    input  logic [7:0]        usb_d,
    input  logic              usb_flaga,
    output logic [1:0]        usb_fifoadr,
    output logic              usb_sloe,
    output logic              usb_slrd,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              pkt_is_data,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic [DATA_W-1:0] pkt_data,
    output logic [7:0]        err_count
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    usb_fifo_byte_reader u_reader (
        .clk_i        (mclk),
        .rst_n_i      (reset),
        .usb_d_i      (usb_d),
        .usb_flaga_i  (usb_flaga),
        .hold_i       (pkt_valid),
        .usb_slrd_o   (usb_slrd),
        .usb_sloe_o   (usb_sloe),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid)
    );

    logic [1:0]        cnt_q,      cnt_d;
    logic              hdr_data_q, hdr_data_d;
    logic [6:0]        hi_q,       hi_d;
    logic [7:0]        mid_q,      mid_d;
    logic              valid_q,    valid_d;
    logic              is_data_q,  is_data_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [7:0]        err_q,      err_d;
`ifdef USB_CMD_ADDR_AUTOINC_EN
    logic [ADDR_W-1:0] cur_q,      cur_d;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        hdr_data_d = hdr_data_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        valid_d    = valid_q;
        is_data_d  = is_data_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
`ifdef USB_CMD_ADDR_AUTOINC_EN
        cur_d      = cur_q;
`endif
        if (valid_q && pkt_ready) begin
            valid_d = 1'b0;
`ifdef USB_CMD_ADDR_AUTOINC_EN
            if (is_data_q) cur_d = cur_q + ADDR_W'(1);
`endif
        end

        // rx_valid never coincides with valid_q: the fetcher is held while a packet is pending.
        if (rx_valid) begin
            case (cnt_q)
                2'd0: begin
                    if (rx_byte == PKT_MARKER) begin
                        hdr_data_d = 1'b1;
                        cnt_d      = 2'd1;
                    end else if (is_addr_hdr(rx_byte)) begin
                        hdr_data_d = 1'b0;
                        hi_d       = rx_byte[6:0];
                        cnt_d      = 2'd1;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                2'd1: begin
                    mid_d = rx_byte;
                    cnt_d = 2'd2;
                end
                default: begin
                    cnt_d   = 2'd0;
                    valid_d = 1'b1;
                    if (hdr_data_q) begin
                        is_data_d = 1'b1;
                        data_d    = {mid_q, rx_byte};
`ifdef USB_CMD_ADDR_AUTOINC_EN
                        addr_d    = cur_q;
`endif
                    end else begin
                        is_data_d = 1'b0;
                        addr_d    = {hi_q, mid_q, rx_byte};
`ifdef USB_CMD_ADDR_AUTOINC_EN
                        cur_d     = {hi_q, mid_q, rx_byte};
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            cnt_q      <= 2'd0;
            hdr_data_q <= 1'b0;
            hi_q       <= '0;
            mid_q      <= '0;
            valid_q    <= 1'b0;
            is_data_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= '0;
`ifdef USB_CMD_ADDR_AUTOINC_EN
            cur_q      <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            hdr_data_q <= hdr_data_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            valid_q    <= valid_d;
            is_data_q  <= is_data_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
`ifdef USB_CMD_ADDR_AUTOINC_EN
            cur_q      <= cur_d;
`endif
        end
    end

    assign usb_fifoadr = FIFO_ADDR;
    assign pkt_valid   = valid_q;
    assign pkt_is_data = is_data_q;
    assign pkt_addr    = addr_q;
    assign pkt_data    = data_q;
    assign err_count   = err_q;

endmodule
